// File: rtl/rv_wb_ctrl.sv
// Writeback merge of ALU and load results onto the single register-file write port, plus operand bypass.
// Latency: ALU beat accepted at edge N writes after N; a load waits in the FIFO and writes one edge after it is popped.
// Backpressure: both producers stall while the load FIFO is full; the FIFO drains when the ALU is idle or blocked.
module rv_wb_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_alu_valid,
    output logic        o_alu_ready,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    input  logic        i_mem_valid,
    output logic        o_mem_ready,
    input  logic [4:0]  i_mem_rd,
    input  logic [31:0] i_mem_data,
    output logic [4:0]  o_rd,
    output logic        o_write,
    output logic [31:0] o_data,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_rf_data1,
    input  logic [31:0] i_rf_data2,
    output logic [31:0] o_op1,
    output logic [31:0] o_op2
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]    fifo_rd  [DEPTH];
    logic [31:0]   fifo_dat [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          not_full;
    logic          alu_acc;
    logic          push;
    logic          pop;

    logic          hit1_q, hit2_q;
    logic          zero1_q, zero2_q;
    logic [31:0]   fwd1_q, fwd2_q;

    // Both producers see the same readiness: the ALU is stalled while loads back up.
    assign not_full    = (count < CW'(DEPTH));
    assign o_mem_ready = not_full;
    assign o_alu_ready = not_full;

    // Arbitration: an accepted ALU beat owns the port, otherwise the FIFO head drains.
    always_comb begin
        alu_acc = i_alu_valid && not_full;
        push    = i_mem_valid && not_full;
        pop     = !alu_acc && (count != '0);
    end

    // FIFO storage needs no reset; only entries below count are ever read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd[wr_ptr]  <= i_mem_rd;
            fifo_dat[wr_ptr] <= i_mem_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Write-port register; a winner targeting x0 is consumed without raising the enable.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_write <= 1'b0;
            o_rd    <= '0;
            o_data  <= '0;
        end else if (alu_acc) begin
            o_write <= (i_alu_rd != 5'd0);
            o_rd    <= i_alu_rd;
            o_data  <= i_alu_data;
        end else if (pop) begin
            o_write <= (fifo_rd[rd_ptr] != 5'd0);
            o_rd    <= fifo_rd[rd_ptr];
            o_data  <= fifo_dat[rd_ptr];
        end else begin
            o_write <= 1'b0;
        end
    end

    // Bypass capture: the write being committed at this edge is invisible in the RF read data.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            zero1_q <= 1'b0;
            zero2_q <= 1'b0;
            fwd1_q  <= '0;
            fwd2_q  <= '0;
        end else begin
            hit1_q  <= o_write && (o_rd == i_rs1);
            hit2_q  <= o_write && (o_rd == i_rs2);
            zero1_q <= (i_rs1 == 5'd0);
            zero2_q <= (i_rs2 == 5'd0);
            fwd1_q  <= o_data;
            fwd2_q  <= o_data;
        end
    end

    assign o_op1 = zero1_q ? 32'd0 : (hit1_q ? fwd1_q : i_rf_data1);
    assign o_op2 = zero2_q ? 32'd0 : (hit2_q ? fwd2_q : i_rf_data2);

endmodule

// File: tb/tb_rv_wb_ctrl.sv
module tb_rv_wb_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  o_rd;
    logic        o_write;
    logic [31:0] o_data;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf_data1, rf_data2;
    logic [31:0] op1, op2;

    always #5 clk = ~clk;

    rv_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
        .i_mem_valid(mem_valid), .o_mem_ready(mem_ready), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
        .o_rd(o_rd), .o_write(o_write), .o_data(o_data),
        .i_rs1(rs1), .i_rs2(rs2), .i_rf_data1(rf_data1), .i_rf_data2(rf_data2),
        .o_op1(op1), .o_op2(op2)
    );

    // Register file environment: synchronous read returning the old value on a coincident write.
    logic [31:0] rf [32];
    logic        rf_init;

    function automatic logic [31:0] init_val(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'(i) * 32'h0101_0101;
    endfunction

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
        end else if (o_write) begin
            rf[o_rd] <= o_data;
        end
        rf_data1 <= rf[rs1];
        rf_data2 <= rf[rs2];
    end

    // Reference model: a queue of pending loads and the architectural register state.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } beat_t;

    beat_t       q[$];
    logic [31:0] arch [32];
    logic        exp_wr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [31:0] exp_op1, exp_op2;
    logic        op_vld;
    int          checks = 0;
    int          errors = 0;
    int          model_writes = 0;
    int          dut_writes = 0;
    logic        a_acc, m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, advance the model across the rising edge, compare at the next falling edge.
    task automatic step(input logic rst,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic [4:0] r1, input logic [4:0] r2,
                        output logic a_ok, output logic m_ok);
        logic  rdy_m;
        beat_t b;
        reset_n   = !rst;
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        mem_valid = mv;  mem_rd = mrd;  mem_data = md;
        rs1 = r1;  rs2 = r2;
        #1;
        rdy_m = (q.size() < DEPTH);
        chk("alu_ready", 32'(alu_ready), 32'(rdy_m));
        chk("mem_ready", 32'(mem_ready), 32'(rdy_m));
        if (exp_wr) arch[exp_rd] = exp_data;
        a_ok = 1'b0;
        m_ok = 1'b0;
        if (rst) begin
            q.delete();
            exp_wr = 1'b0;
            op_vld = 1'b0;
        end else begin
            op_vld  = 1'b1;
            exp_op1 = (r1 == 5'd0) ? 32'd0 : arch[r1];
            exp_op2 = (r2 == 5'd0) ? 32'd0 : arch[r2];
            a_ok = av && rdy_m;
            m_ok = mv && rdy_m;
            if (a_ok) begin
                exp_wr = (ard != 5'd0); exp_rd = ard; exp_data = ad;
            end else if (q.size() > 0) begin
                b = q.pop_front();
                exp_wr = (b.rd != 5'd0); exp_rd = b.rd; exp_data = b.data;
            end else begin
                exp_wr = 1'b0;
            end
            if (m_ok) q.push_back('{rd: mrd, data: md});
            if (exp_wr) model_writes++;
        end
        @(negedge clk);
        if (o_write) dut_writes++;
        chk("o_write", 32'(o_write), 32'(exp_wr));
        if (exp_wr) begin
            chk("o_rd", 32'(o_rd), 32'(exp_rd));
            chk("o_data", o_data, exp_data);
        end
        if (op_vld) begin
            chk("o_op1", op1, exp_op1);
            chk("o_op2", op2, exp_op2);
        end
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2, a_acc, m_acc);
    endtask

    logic        r_rst, r_av, r_mv, hold_a, hold_m;
    logic [4:0]  r_ard, r_mrd;
    logic [31:0] r_ad, r_md;

    initial begin
        for (int i = 0; i < 32; i++) arch[i] = init_val(i);
        exp_wr = 1'b0; exp_rd = '0; exp_data = '0; op_vld = 1'b0;
        exp_op1 = '0; exp_op2 = '0;

        // Initial reset, held over several edges while the register file is loaded.
        rf_init = 1'b1;
        reset_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        rs1 = 5'd3; rs2 = 5'd0;
        repeat (3) @(negedge clk);
        rf_init = 1'b0;
        chk("rst_write", 32'(o_write), 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_op1_pass", op1, 32'h0303_0303);
        chk("rst_op2_pass", op2, 32'hFFFF_FFFF);

        // Single ALU beat.
        step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, a_acc, m_acc);
        chk("alu_write", 32'(o_write), 32'd1);
        chk("alu_rd", 32'(o_rd), 32'd5);
        chk("alu_data", o_data, 32'h1234_5678);
        idle(5'd5, 5'd1);
        chk("alu_write_drop", 32'(o_write), 32'd0);

        // Single load with the ALU idle; then a load to x0.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd0, 5'd0, a_acc, m_acc);
        chk("ld_wait", 32'(o_write), 32'd0);
        idle(5'd7, 5'd0);
        chk("ld_write", 32'(o_write), 32'd1);
        chk("ld_rd", 32'(o_rd), 32'd7);
        chk("ld_data", o_data, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555_5555, 5'd7, 5'd0, a_acc, m_acc);
        idle(5'd7, 5'd0);
        chk("ld_x0_nowrite", 32'(o_write), 32'd0);
        idle(5'd0, 5'd0);

        // Bypass of a write coinciding with the read.
        step(1'b0, 1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, a_acc, m_acc);
        idle(5'd9, 5'd0);
        chk("byp_op1", op1, 32'hA5A5_A5A5);
        chk("byp_op2_x0", op2, 32'd0);

        // Loads colliding with a streaming ALU until the FIFO fills.
        step(1'b0, 1'b1, 5'd10, 32'h0000_0010, 1'b1, 5'd1, 32'h1000_0001, 5'd1, 5'd10, a_acc, m_acc);
        step(1'b0, 1'b1, 5'd11, 32'h0000_0011, 1'b1, 5'd2, 32'h1000_0002, 5'd2, 5'd11, a_acc, m_acc);
        chk("full_mem_ready", 32'(mem_ready), 32'd0);
        chk("full_alu_ready", 32'(alu_ready), 32'd0);
        step(1'b0, 1'b1, 5'd12, 32'h0000_0012, 1'b1, 5'd3, 32'h1000_0003, 5'd10, 5'd1, a_acc, m_acc);
        chk("full_head_rd", 32'(o_rd), 32'd1);
        step(1'b0, 1'b1, 5'd12, 32'h0000_0012, 1'b1, 5'd3, 32'h1000_0003, 5'd1, 5'd11, a_acc, m_acc);
        chk("resume_alu_rd", 32'(o_rd), 32'd12);
        idle(5'd12, 5'd2);
        chk("drain_rd2", 32'(o_rd), 32'd2);
        idle(5'd2, 5'd3);
        chk("drain_rd3", 32'(o_rd), 32'd3);
        idle(5'd3, 5'd12);

        // Reset with two queued loads and a write on the port.
        step(1'b0, 1'b1, 5'd20, 32'h0000_0020, 1'b1, 5'd4, 32'h1000_0004, 5'd0, 5'd0, a_acc, m_acc);
        step(1'b0, 1'b1, 5'd21, 32'h0000_0021, 1'b1, 5'd5, 32'h1000_0005, 5'd0, 5'd0, a_acc, m_acc);
        chk("prerst_write", 32'(o_write), 32'd1);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd21, 5'd4, a_acc, m_acc);
        chk("midrst_write", 32'(o_write), 32'd0);
        chk("midrst_alu_ready", 32'(alu_ready), 32'd1);
        chk("midrst_mem_ready", 32'(mem_ready), 32'd1);
        idle(5'd21, 5'd4);
        idle(5'd4, 5'd5);
        idle(5'd5, 5'd20);
        chk("postrst_nowrite", 32'(o_write), 32'd0);

        // Randomized mix with producers holding beats until accepted.
        hold_a = 1'b0; hold_m = 1'b0;
        r_ard = '0; r_ad = '0; r_mrd = '0; r_md = '0; r_av = 1'b0; r_mv = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            if (!hold_a) begin
                r_av  = ($urandom_range(0, 2) != 0);
                r_ard = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
                r_ad  = $urandom;
            end
            if (!hold_m) begin
                r_mv  = ($urandom_range(0, 1) != 0);
                r_mrd = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
                r_md  = $urandom;
            end
            if (r_rst) begin
                r_av = 1'b0;
                r_mv = 1'b0;
            end
            step(r_rst, r_av, r_ard, r_ad, r_mv, r_mrd, r_md,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a_acc, m_acc);
            hold_a = r_av && !a_acc;
            hold_m = r_mv && !m_acc;
        end
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        chk("write_count", 32'(dut_writes), 32'(model_writes));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_wb_ctrl.md
# rv_wb_ctrl

Writeback controller on the producer side of the core register file. It merges single-cycle ALU results and variable-latency load/memory results into the register file's single write port, and drives that port's rd, write-enable and data inputs. It also supplies bypassed operands: the register file reads synchronously and returns the old value when a read and a write to the same register coincide, so this block corrects the operands and forces x0 to zero. It sits between the execute/LSU stages and the register file.

## Interface
- DEPTH, 2: number of load-result FIFO entries; must be a power of two, ≥2.
- i_clk  in  1  clock; all state on rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_alu_valid  in  1  ALU result valid.
- o_alu_ready  out  1  ALU result accepted this cycle when high with valid.
- i_alu_rd  in  5  ALU destination register.
- i_alu_data  in  32  ALU result.
- i_mem_valid  in  1  load result valid.
- o_mem_ready  out  1  load result accepted this cycle when high with valid.
- i_mem_rd  in  5  load destination register.
- i_mem_data  in  32  load result.
- o_rd  out  5  register-file write address.
- o_write  out  1  register-file write enable.
- o_data  out  32  register-file write data.
- i_rs1, i_rs2  in  5 each  read addresses, presented in the same cycle as to the register file.
- i_rf_data1, i_rf_data2  in  32 each  register-file read outputs, valid one cycle after the address.
- o_op1, o_op2  out  32 each  bypassed operands, aligned with i_rf_data1/2.

## Operation
**FIFO**
- DEPTH-entry load FIFO holds rd and data.
- Pointers wrap modulo DEPTH.
- count is 0..DEPTH.

**Handshakes**
- o_mem_ready = (count < DEPTH), combinational from registered state.
- Push on i_mem_valid && o_mem_ready.
- o_alu_ready = (count < DEPTH).
- When the FIFO is full, the ALU holds rd/data with valid high until accepted.

**Arbitration, once per cycle**
- (a) ALU beat accepted: it takes the write port; the FIFO head waits.
- (b) Otherwise, if count > 0: pop the head and it takes the port.
- (c) Otherwise: no write.
- The FIFO therefore drains whenever the ALU is idle or the FIFO is full.
- Push and pop in the same cycle: count unchanged, pointers both advance.

**Write-port register**
- o_write, o_rd and o_data are registered, loaded from the winner.
- If the winner's rd == 0, the beat is consumed but o_write = 0.

**Bypass**
- Each edge captures, for port k:
  - hit_k = o_write && (o_rd == i_rsk)
  - fwd_k = o_data
  - zero_k = (i_rsk == 0)
- The hit compare uses the pre-edge o_write/o_rd, i.e. the write the register file commits at that same edge.
- o_opk = zero_k ? 0 : hit_k ? fwd_k : i_rf_datak.

**Reset**
- Registers:
  - o_write = 0, o_rd = 0, o_data = 0
  - count = 0, pointers = 0
  - hit/zero/fwd registers = 0
- Outputs after reset: o_alu_ready = 1, o_mem_ready = 1, o_op1/o_op2 = i_rf_data1/2 (pass-through).
- Reset asserted mid-operation discards FIFO contents and any pending write: o_write = 0 on the cycle after the reset edge. No partial write is issued.

## Timing
- ALU beat accepted at edge N: o_write/o_rd/o_data valid after edge N; the register file commits at edge N+1.
- Load pushed at edge N into an empty FIFO with the ALU idle at N+1: popped at edge N+1, o_write after N+1, committed at N+2.
- Load waits one extra cycle per consecutive ALU beat, except when the FIFO is full.
- Read address presented at N: o_opk valid after edge N; it reflects every write committed up to and including edge N.
- Throughput: one register write per cycle.
- o_alu_ready and o_mem_ready change only after edges.

## Test plan
- Reset, then ALU beat rd=5 data=0x12345678 at cycle 1 -> o_write=1, o_rd=5, o_data=0x12345678 in cycle 2; o_write=0 in cycle 3.
- Load rd=7 data=0xDEADBEEF with ALU idle -> o_write in the second cycle after acceptance, rd=7. Load with rd=0 -> accepted, o_write stays 0.
- Back-to-back: 3 loads (rd 1,2,3) while ALU streams continuously (DEPTH=2) -> o_mem_ready drops after 2 pushes. When full, o_alu_ready=0 and the load head writes. Final write order is all ALU beats accepted before full, then rd1, then ALU/loads interleaved; no beat lost or duplicated.
- Bypass: o_write=1, o_rd=9, o_data=0xA5A5A5A5 while i_rs1=9 and i_rf_data1=old value 0x0 -> next cycle o_op1=0xA5A5A5A5. i_rs2=0 with i_rf_data2=0xFFFFFFFF -> o_op2=0.
- Reset asserted with FIFO holding 2 entries and o_write=1 -> after the reset edge o_write=0, both readies 1, no queued write ever appears.
- Random mix of ALU/load beats with random readiness versus a reference model: every non-zero rd write appears once, ALU beats in order, loads in order, and o_op values always equal the model's architectural register state.
